// File: rtl/poly1305_core.sv
// rtl/poly1305_core.sv - Poly1305 block datapath: h = ((h + m_pad) * r) mod 2^130-5, tag = h + s
// Bit-serial multiply (one r bit per clock, MSB first) with per-step reduction keeps h < P.
module poly1305_core (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [127:0] r,
  input  logic [127:0] s,
  input  logic [127:0] m,
  input  logic [4:0]   mbytes,
  input  logic         ld,
  input  logic         first,
  input  logic         fb,
  output logic         busy,
  output logic [127:0] p,
  output logic         rdy
);

  localparam logic [131:0] P     = 132'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_MUL, S_END, S_FIN} state_t;

  state_t       r_state;
  logic [129:0] r_h;
  logic [129:0] r_a;
  logic [129:0] r_acc;
  logic [127:0] r_rq;
  logic [127:0] r_sq;
  logic [127:0] r_p;
  logic [128:0] r_mpad;
  logic         r_fb;
  logic         r_rdy;
  logic [6:0]   r_count;

  logic [4:0]   w_nb;
  logic [128:0] w_mpad;
  logic [131:0] w_add;
  logic [131:0] w_add_red;
  logic [131:0] w_t0;
  logic [131:0] w_t1;
  logic [131:0] w_t2;
  logic [127:0] w_tag;
  logic         w_unused;

  // Out-of-range byte counts on a final block fall back to a full block.
  assign w_nb = (fb && mbytes != 5'd0 && mbytes <= 5'd16) ? mbytes : 5'd16;

  always_comb begin
    w_mpad = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(w_nb)) w_mpad[8*i +: 8] = m[8*i +: 8];
    end
    w_mpad = w_mpad | (129'd1 << {w_nb, 3'b000});
  end

  assign w_add     = {2'b00, r_h} + {3'b000, r_mpad};
  assign w_add_red = (w_add >= P) ? (w_add - P) : w_add;

  // t = 2*acc + bit*a stays below 3P, so two conditional subtractions fully reduce it.
  assign w_t0 = {1'b0, r_acc, 1'b0} + (r_rq[r_count] ? {2'b00, r_a} : 132'd0);
  assign w_t1 = (w_t0 >= P) ? (w_t0 - P) : w_t0;
  assign w_t2 = (w_t1 >= P) ? (w_t1 - P) : w_t1;

  assign w_tag    = r_acc[127:0] + r_sq;
  assign w_unused = ^{w_add_red[131:130], w_t2[131:130]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_a     <= '0;
      r_acc   <= '0;
      r_rq    <= '0;
      r_sq    <= '0;
      r_p     <= '0;
      r_mpad  <= '0;
      r_fb    <= 1'b0;
      r_rdy   <= 1'b0;
      r_count <= '0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ld) begin
            r_mpad <= w_mpad;
            r_fb   <= fb;
            if (first) begin
              r_rq <= r & CLAMP;
              r_sq <= s;
              r_h  <= '0;
            end
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_a     <= w_add_red[129:0];
          r_acc   <= '0;
          r_count <= 7'd127;
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_acc   <= w_t2[129:0];
          r_count <= r_count - 7'd1;
          if (r_count == 7'd0) r_state <= r_fb ? S_FIN : S_END;
        end
        S_END: begin
          r_h     <= r_acc;
          r_state <= S_IDLE;
        end
        S_FIN: begin
          r_h     <= r_acc;
          r_p     <= w_tag;
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign p    = r_p;
  assign rdy  = r_rdy;

endmodule
